// File: rtl/sdram_rd_arbiter_pkg.sv
// Shared definitions for the SDRAM read arbiter: FSM encoding, default
// address width, timeout fill byte and a width helper.
package sdram_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int         DEFAULT_AW   = 25;
  localparam logic [7:0] TIMEOUT_FILL = 8'hFF;

  // ceil(log2(n)), never less than one bit
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_rd_arbiter_rr_pick.sv
// Combinational round-robin selector: first pending index searched
// cyclically starting just after the last granted requester.
module rr_pick
  import sdram_rd_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int GW   = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] i_pending,
  input  logic [GW-1:0]   i_last_grant,
  output logic [GW-1:0]   o_grant,
  output logic            o_valid
);

  always_comb begin
    logic [GW-1:0] idx;
    // NOTE: every output gets a default before the search so no path leaves
    // it unassigned, which would otherwise infer a latch.
    o_grant = '0;
    o_valid = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = GW'((int'(i_last_grant) + k) % NREQ);
      if (!o_valid && i_pending[idx]) begin
        o_grant = idx;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_rd_arbiter.sv
// Toggle-handshake read arbiter: round-robin shares one SDRAM read port
// among NREQ requesters, with a per-transfer timeout and drain recovery.
module sdram_rd_arbiter
  import sdram_rd_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = DEFAULT_AW,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ-1:0]    req_rd,
  output logic [NREQ-1:0]    req_ack,
  output logic [NREQ*8-1:0]  req_data,
  output logic [AW-1:0]      sdram_addr,
  output logic               sdram_rd,
  input  logic               sdram_ack,
  input  logic [7:0]         sdram_data,
  output logic               timeout_err
);

  localparam int             GW      = clog2_min1(NREQ);
  localparam int             CW      = clog2_min1(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT);

  state_t             r_state, w_state_next;
  logic [GW-1:0]      r_grant, r_last_grant, w_pick;
  logic               w_pick_valid;
  logic [CW-1:0]      r_cnt, w_cnt_inc;
  logic [NREQ-1:0]    r_req_ack, w_pending;
  logic [NREQ*8-1:0]  r_req_data;
  logic [AW-1:0]      r_sdram_addr;
  logic               r_sdram_rd, r_timeout_err;
  logic               w_match, w_issue, w_done, w_expire;

  assign w_pending = req_rd ^ r_req_ack;
  assign w_match   = (sdram_ack == r_sdram_rd);
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  rr_pick #(.NREQ(NREQ), .GW(GW)) u_rr_pick (
    .i_pending    (w_pending),
    .i_last_grant (r_last_grant),
    .o_grant      (w_pick),
    .o_valid      (w_pick_valid)
  );

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_done       = 1'b0;
    w_expire     = 1'b0;
    unique case (r_state)
      IDLE: if (w_pick_valid) begin
        w_issue      = 1'b1;
        w_state_next = WAIT;
      end
      WAIT: if (w_match) begin
        w_done       = 1'b1;
        w_state_next = IDLE;
      end else if (w_cnt_inc == CNT_MAX) begin
        w_expire     = 1'b1;
        w_state_next = DRAIN;
      end
      DRAIN: if (w_match) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: toggle-handshake state reloads from the live partner signals so
      // leaving reset never looks like a fresh request or acknowledge.
      r_sdram_rd    <= sdram_ack;
      r_req_ack     <= req_rd;
      r_req_data    <= '0;
      r_sdram_addr  <= '0;
      r_grant       <= '0;
      r_last_grant  <= GW'(NREQ - 1);
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_issue) begin
        r_grant      <= w_pick;
        r_sdram_addr <= req_addr[w_pick*AW +: AW];
        r_sdram_rd   <= ~r_sdram_rd;
        r_cnt        <= '0;
      end
      if (r_state == WAIT && !w_match) r_cnt <= w_cnt_inc;
      if (w_done || w_expire) begin
        r_req_data[r_grant*8 +: 8] <= w_done ? sdram_data : TIMEOUT_FILL;
        r_req_ack[r_grant]         <= ~r_req_ack[r_grant];
        r_last_grant               <= r_grant;
      end
      if (w_expire) r_timeout_err <= 1'b1;
    end
  end

  assign req_ack     = r_req_ack;
  assign req_data    = r_req_data;
  assign sdram_addr  = r_sdram_addr;
  assign sdram_rd    = r_sdram_rd;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_sdram_rd_arbiter.sv
// Directed bench for sdram_rd_arbiter: vector table of single transfers
// plus hand-written arbitration, timeout and reset sequences.
module tb_sdram_rd_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 25;
  localparam int TMO  = 15;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_rd, req_ack;
  logic [NREQ*8-1:0]  req_data;
  logic [AW-1:0]      sdram_addr;
  logic               sdram_rd, sdram_ack;
  logic [7:0]         sdram_data;
  logic               timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  logic            exp_rd;
  logic [NREQ-1:0] exp_ack;
  logic [7:0]      exp_data [NREQ];

  int   rd_toggles = 0;
  logic prev_rd;
  int   base;

  typedef struct {
    int          who;
    logic [AW-1:0] addr;
    int          lat;
    logic [7:0]  data;
    logic [AW-1:0] exp_addr;
    logic [7:0]  exp_byte;
  } vec_t;
  vec_t vecs [4];

  sdram_rd_arbiter #(.NREQ(NREQ), .AW(AW), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_addr    (req_addr),
    .req_rd      (req_rd),
    .req_ack     (req_ack),
    .req_data    (req_data),
    .sdram_addr  (sdram_addr),
    .sdram_rd    (sdram_rd),
    .sdram_ack   (sdram_ack),
    .sdram_data  (sdram_data),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // counts downstream request toggles outside reset
  always @(posedge clk) begin
    #1;
    if (!reset && sdram_rd !== prev_rd) rd_toggles++;
    prev_rd = sdram_rd;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_data(input string tag);
    check({tag, "_data0"}, 32'(req_data[7:0]),  32'(exp_data[0]));
    check({tag, "_data1"}, 32'(req_data[15:8]), 32'(exp_data[1]));
  endtask

  task automatic run_vec(input vec_t v);
    req_addr[v.who*AW +: AW] = v.addr;
    req_rd[v.who] = ~req_rd[v.who];
    tick(1);
    exp_rd = ~exp_rd;
    check("vec_grant_rd",   32'(sdram_rd),   32'(exp_rd));
    check("vec_grant_addr", 32'(sdram_addr), 32'(v.exp_addr));
    req_addr[v.who*AW +: AW] = ~v.addr;
    tick(v.lat);
    check("vec_ack_early", 32'(req_ack), 32'(exp_ack));
    sdram_data = v.data;
    sdram_ack  = exp_rd;
    tick(1);
    exp_ack[v.who]  = ~exp_ack[v.who];
    exp_data[v.who] = v.exp_byte;
    check("vec_ack",       32'(req_ack),    32'(exp_ack));
    check("vec_addr_hold", 32'(sdram_addr), 32'(v.exp_addr));
    check("vec_rd_once",   32'(sdram_rd),   32'(exp_rd));
    check_data("vec");
  endtask

  initial begin
    vecs[0] = '{0, 25'h0000123, 3,  8'h5A, 25'h0000123, 8'h5A};
    vecs[1] = '{1, 25'h1FFFFFF, 1,  8'hA5, 25'h1FFFFFF, 8'hA5};
    vecs[2] = '{0, 25'h0000000, 0,  8'h00, 25'h0000000, 8'h00};
    vecs[3] = '{1, 25'h00ABCDE, 12, 8'h3C, 25'h00ABCDE, 8'h3C};

    reset      = 1'b1;
    req_rd     = 2'b01;
    sdram_ack  = 1'b1;
    req_addr   = '0;
    sdram_data = 8'h77;
    tick(2);
    reset = 1'b0;
    exp_rd      = 1'b1;
    exp_ack     = 2'b01;
    exp_data[0] = 8'h00;
    exp_data[1] = 8'h00;
    check("rst_sdram_rd", 32'(sdram_rd),    32'(exp_rd));
    check("rst_req_ack",  32'(req_ack),     32'(exp_ack));
    check("rst_addr",     32'(sdram_addr),  32'h0);
    check("rst_tmo",      32'(timeout_err), 32'h0);
    check_data("rst");

    // both requesters at once: 0 first, then 1, two downstream toggles
    base = rd_toggles;
    req_addr[0*AW +: AW] = 25'h10;
    req_addr[1*AW +: AW] = 25'h20;
    req_rd = ~req_rd;
    tick(1);
    exp_rd = ~exp_rd;
    check("sim_rd0",   32'(sdram_rd),   32'(exp_rd));
    check("sim_addr0", 32'(sdram_addr), 32'h10);
    sdram_data = 8'h11;
    sdram_ack  = exp_rd;
    tick(1);
    exp_ack[0] = ~exp_ack[0];
    exp_data[0] = 8'h11;
    check("sim_ack0",  32'(req_ack),  32'(exp_ack));
    check("sim_idle",  32'(sdram_rd), 32'(exp_rd));
    check_data("sim0");
    tick(1);
    exp_rd = ~exp_rd;
    check("sim_rd1",   32'(sdram_rd),   32'(exp_rd));
    check("sim_addr1", 32'(sdram_addr), 32'h20);
    sdram_data = 8'h22;
    sdram_ack  = exp_rd;
    tick(1);
    exp_ack[1] = ~exp_ack[1];
    exp_data[1] = 8'h22;
    check("sim_ack1", 32'(req_ack), 32'(exp_ack));
    check_data("sim1");
    tick(3);
    check("sim_toggles", 32'(rd_toggles - base), 32'd2);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // requester 0 re-requests right after each ack while 1 stays pending
    req_addr[0*AW +: AW] = 25'h100;
    req_addr[1*AW +: AW] = 25'h200;
    req_rd = ~req_rd;
    for (int g = 0; g < 4; g++) begin
      int who;
      who = g % 2;
      tick(1);
      exp_rd = ~exp_rd;
      check("fair_rd",   32'(sdram_rd),   32'(exp_rd));
      check("fair_addr", 32'(sdram_addr), (who == 0) ? 32'h100 : 32'h200);
      sdram_data = 8'(8'hC0 + g);
      sdram_ack  = exp_rd;
      tick(1);
      exp_ack[who]  = ~exp_ack[who];
      exp_data[who] = 8'(8'hC0 + g);
      check("fair_ack", 32'(req_ack), 32'(exp_ack));
      check_data("fair");
      if (g < 2) req_rd[who] = ~req_rd[who];
    end

    // timeout on requester 1, then drain, then a fresh grant to 0
    base = rd_toggles;
    req_addr[1*AW +: AW] = 25'h1555;
    req_rd[1] = ~req_rd[1];
    tick(1);
    exp_rd = ~exp_rd;
    check("tmo_rd",   32'(sdram_rd),   32'(exp_rd));
    check("tmo_addr", 32'(sdram_addr), 32'h1555);
    tick(TMO - 1);
    check("tmo_ack_early", 32'(req_ack),     32'(exp_ack));
    check("tmo_err_early", 32'(timeout_err), 32'h0);
    tick(1);
    exp_ack[1]  = ~exp_ack[1];
    exp_data[1] = 8'hFF;
    check("tmo_ack", 32'(req_ack),     32'(exp_ack));
    check("tmo_err", 32'(timeout_err), 32'h1);
    check_data("tmo");
    req_addr[0*AW +: AW] = 25'h0777;
    req_rd[0] = ~req_rd[0];
    tick(4);
    check("drain_no_rd",  32'(sdram_rd), 32'(exp_rd));
    check("drain_no_ack", 32'(req_ack),  32'(exp_ack));
    sdram_data = 8'h99;
    sdram_ack  = exp_rd;
    tick(1);
    check("drain_exit_rd", 32'(sdram_rd), 32'(exp_rd));
    check_data("drain");
    sdram_data = 8'hC3;
    tick(1);
    exp_rd = ~exp_rd;
    check("post_rd",   32'(sdram_rd),   32'(exp_rd));
    check("post_addr", 32'(sdram_addr), 32'h0777);
    sdram_ack = exp_rd;
    tick(1);
    exp_ack[0]  = ~exp_ack[0];
    exp_data[0] = 8'hC3;
    check("post_ack",     32'(req_ack),     32'(exp_ack));
    check("post_err",     32'(timeout_err), 32'h1);
    check("tmo_toggles",  32'(rd_toggles - base), 32'd2);
    check_data("post");

    // reset while a transfer is outstanding
    req_addr[0*AW +: AW] = 25'h0BEEF;
    req_rd[0] = ~req_rd[0];
    tick(1);
    exp_rd = ~exp_rd;
    check("rw_rd", 32'(sdram_rd), 32'(exp_rd));
    reset = 1'b1;
    tick(2);
    reset  = 1'b0;
    exp_rd = sdram_ack;
    exp_ack = req_rd;
    check("rw_rd_eq_ack",  32'(sdram_rd),    32'(exp_rd));
    check("rw_ack_eq_rd",  32'(req_ack),     32'(exp_ack));
    check("rw_err_clr",    32'(timeout_err), 32'h0);
    check("rw_addr_clr",   32'(sdram_addr),  32'h0);
    check("rw_data_clr",   32'(req_data),    32'h0);
    base = rd_toggles;
    tick(5);
    check("rw_no_rd_tog",  32'(rd_toggles - base), 32'd0);
    check("rw_no_ack_tog", 32'(req_ack),     32'(exp_ack));
    check("rw_rd_stable",  32'(sdram_rd),    32'(exp_rd));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdram_rd_arbiter.md
SDRAM_RD_ARBITER -- requirements
Module: sdram_rd_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter NREQ, default 2: number of read requesters (0 = cassette, 1 = cartridge/ROM loader).
REQ-003 Parameter AW, default 25: SDRAM byte-address width.
REQ-004 Parameter TIMEOUT, default 1023: max cycles to wait for downstream ack.
REQ-005 Port clk, input, 1: system clock.
REQ-006 Port reset, input, 1: synchronous active-high reset.
REQ-007 Port req_addr, input, NREQ*AW: per-requester byte address, slice i = requester i.
REQ-008 Port req_rd, input, NREQ: per-requester toggle request.
REQ-009 Port req_ack, output, NREQ: per-requester toggle acknowledge.
REQ-010 Port req_data, output, NREQ*8: per-requester returned byte, held until that requester's next completion.
REQ-011 Port sdram_addr, output, AW: downstream address.
REQ-012 Port sdram_rd, output, 1: downstream toggle request.
REQ-013 Port sdram_ack, input, 1: downstream toggle ack.
REQ-014 Port sdram_data, input, 8: downstream read byte, valid when sdram_ack == sdram_rd.
REQ-015 Port timeout_err, output, 1: sticky flag, set on any downstream timeout.

Function
REQ-016 Requester i SHALL be pending when req_rd[i] != req_ack[i]; the requester must not toggle req_rd[i] again while pending, and any extra toggle is ignored until completion.
REQ-017 FSM states SHALL be IDLE, WAIT, DRAIN.
REQ-018 IDLE: if any requester is pending, grant the first pending index searched cyclically from last_grant+1, latch its address into sdram_addr, toggle sdram_rd, and enter WAIT, with sdram_rd changing on the clock edge after the pending condition is sampled.
REQ-019 WAIT: when sdram_ack == sdram_rd, latch sdram_data into req_data[grant], toggle req_ack[grant], set last_grant = grant, and return to IDLE in the same edge (ack visible 1 cycle after downstream match).
REQ-020 Minimum turnaround SHALL be 1 cycle per IDLE plus 1 per WAIT, so back-to-back grants are issued no faster than every 2 cycles.
REQ-021 A WAIT cycle counter SHALL clear on entry to WAIT; when it reaches TIMEOUT without a match, the FSM drives req_data[grant]=8'hFF, toggles req_ack[grant], sets timeout_err, updates last_grant, and enters DRAIN.
REQ-022 DRAIN SHALL issue nothing and return to IDLE on the first cycle sdram_ack == sdram_rd, discarding sdram_data.
REQ-023 If all NREQ requesters are pending simultaneously, service order SHALL be strict round-robin, with no requester granted twice before each other pending one is granted once.
REQ-024 sdram_addr SHALL hold its value outside IDLE grant edges, and changing req_addr of the granted requester during WAIT has no effect.
REQ-025 Counter width SHALL be clog2(TIMEOUT+1), and the counter saturates without wrapping.
REQ-026 The grant index SHALL be clog2(NREQ) bits (min 1), and last_grant wraps NREQ-1 -> 0.

Reset
REQ-027 On reset: state=IDLE, sdram_rd loads current sdram_ack (no spurious request), req_ack loads current req_rd (pending requests dropped), req_data=0, sdram_addr=0, last_grant=NREQ-1, counter=0, timeout_err=0.
REQ-028 Reset asserted during WAIT SHALL abandon the transfer without toggling any req_ack.

Structure
REQ-029 Shared package SHALL hold the FSM state encoding (IDLE=0, WAIT=1, DRAIN=2), the default AW and the timeout fill byte 8'hFF.
REQ-030 One sub-module SHALL exist: rr_pick (combinational round-robin first-pending selector, inputs pending vector and last_grant, outputs grant index and valid).

Verification
REQ-031 Single request: req_rd[0] toggles with addr 0x000123, downstream acks 3 cycles later with 8'h5A -> sdram_addr=0x000123, req_data[0]=8'h5A, req_ack[0] toggles 1 cycle after the ack.
REQ-032 Simultaneous: both requesters toggle in the same cycle after reset -> requester 0 served first, then 1, sdram_rd toggles exactly twice.
REQ-033 Fairness: requester 0 re-requests immediately after each ack while 1 stays pending -> grants alternate 0,1,0,1.
REQ-034 Timeout: TIMEOUT=15, no downstream ack -> after 15 WAIT cycles req_data=8'hFF, req_ack toggles, timeout_err=1, no new sdram_rd toggle until the late ack arrives.
REQ-035 Reset mid-WAIT: reset with sdram_ack != sdram_rd -> after reset sdram_rd == sdram_ack, req_ack == req_rd, no toggles follow.
